ram_rr_arbiter: RTL and testbench

- Shares one single-port synchronous RAM (ADDR_W-bit address, DATA_W-bit data, en/we/address/din in, dout out) between two requesters, A and B.
- Each cycle, at most one request is forwarded to the RAM. A round-robin pointer decides who wins under contention.
- Read data is routed back to the originating requester after the fixed RAM read latency, tagged by a per-stage owner pipeline.
- Sits between client logic and the RAM macro in the RAM subsystem.

---
 rtl/ram_rr_arbiter_if.sv | 35 +++
 rtl/ram_rr_arbiter.sv | 159 +++++++++++++++
 tb/tb_ram_rr_arbiter.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/ram_rr_arbiter_if.sv
// Requester-side bus of the RAM arbiter: one request/grant handshake plus
// the tagged read-return path. The client drives through the master modport
// and the arbiter answers through the slave modport.
interface ram_rr_arbiter_if #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              gnt;
    logic              rvalid;
    logic [DATA_W-1:0] rdata;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  gnt,
        input  rvalid,
        input  rdata
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output gnt,
        output rvalid,
        output rdata
    );
endinterface

// File: rtl/ram_rr_arbiter.sv
// Two-requester round-robin arbiter in front of a single-port synchronous RAM.
// At most one access per cycle goes to the RAM; the grant is combinational so
// the winning access is issued in the same cycle it is granted. Read data
// comes back RD_LAT cycles later and is steered to its requester by an
// owner/valid shift pipeline that mirrors the RAM read latency.
module ram_rr_arbiter #(
    parameter int ADDR_W = 5,
    parameter int DATA_W = 32,
    parameter int RD_LAT = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    ram_rr_arbiter_if.slave      a,
    ram_rr_arbiter_if.slave      b,
    output logic                 ram_en,
    output logic                 ram_we,
    output logic [ADDR_W-1:0]    ram_addr,
    output logic [DATA_W-1:0]    ram_din,
    input  logic [DATA_W-1:0]    ram_dout,
    output logic                 busy
);

    localparam int LAST = RD_LAT - 1;

    // Identifies a requester; also used as the round-robin pointer value
    // naming the requester that wins the next tie.
    typedef enum logic {
        OWNER_A = 1'b0,
        OWNER_B = 1'b1
    } owner_e;

    owner_e              prio;
    logic                a_win;
    logic                b_win;
    logic                issue_read;
    owner_e              issue_owner;
    logic [RD_LAT-1:0]   pipe_valid;
    owner_e              pipe_owner [RD_LAT];
    logic                ret_valid;
    owner_e              ret_owner;

    // Combinational arbitration: a lone requester always wins, a tie goes to
    // the requester named by prio, and nothing is granted while in reset.
    always_comb begin
        a_win = 1'b0;
        b_win = 1'b0;
        if (!rst) begin
            unique case ({a.req, b.req})
                2'b10:   a_win = 1'b1;
                2'b01:   b_win = 1'b1;
                2'b11: begin
                    a_win = (prio == OWNER_A);
                    b_win = (prio == OWNER_B);
                end
                default: ;
            endcase
        end
    end

    assign a.gnt = a_win;
    assign b.gnt = b_win;

    // Round-robin pointer: after a grant the other requester is favoured,
    // and an idle cycle leaves the pointer where it was.
    always_ff @(posedge clk) begin
        if (rst) begin
            prio <= OWNER_A;
        end else if (a_win) begin
            prio <= OWNER_B;
        end else if (b_win) begin
            prio <= OWNER_A;
        end
    end

    // RAM drive muxed from the winner; everything idles at zero without a grant.
    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (a_win) begin
            ram_en   = 1'b1;
            ram_we   = a.we;
            ram_addr = a.addr;
            ram_din  = a.wdata;
        end else if (b_win) begin
            ram_en   = 1'b1;
            ram_we   = b.we;
            ram_addr = b.addr;
            ram_din  = b.wdata;
        end
    end

    // Classify the access issued this cycle for the return pipeline: only
    // granted reads occupy a slot, and the owner tag follows the winner.
    always_comb begin
        issue_read  = 1'b0;
        issue_owner = OWNER_A;
        if (a_win) begin
            issue_read  = ~a.we;
            issue_owner = OWNER_A;
        end else if (b_win) begin
            issue_read  = ~b.we;
            issue_owner = OWNER_B;
        end
    end

    // Valid bits of the return pipeline; reset drops every read in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            pipe_valid <= '0;
        end else begin
            pipe_valid[0] <= issue_read;
            for (int i = 1; i < RD_LAT; i++) begin
                pipe_valid[i] <= pipe_valid[i-1];
            end
        end
    end

    // Owner tags travel alongside the valid bits; they are only looked at
    // when the matching valid bit is set, so they need no reset.
    always_ff @(posedge clk) begin
        pipe_owner[0] <= issue_owner;
        for (int i = 1; i < RD_LAT; i++) begin
            pipe_owner[i] <= pipe_owner[i-1];
        end
    end

    // The last pipeline stage lines up with ram_dout. A read reaching the end
    // during the reset cycle is suppressed so that reads in flight at reset
    // never surface.
    always_comb begin
        ret_valid = pipe_valid[LAST] & ~rst;
        ret_owner = pipe_owner[LAST];
    end

    // Steer returning data to its owner; rdata stays zero whenever rvalid is low.
    always_comb begin
        a.rvalid = 1'b0;
        a.rdata  = '0;
        b.rvalid = 1'b0;
        b.rdata  = '0;
        if (ret_valid) begin
            if (ret_owner == OWNER_A) begin
                a.rvalid = 1'b1;
                a.rdata  = ram_dout;
            end else begin
                b.rvalid = 1'b1;
                b.rdata  = ram_dout;
            end
        end
    end

    assign busy = |pipe_valid;

    // Both requesters must never be granted in the same cycle.
    gnt_onehot: assert property (@(posedge clk) !(a_win && b_win));

endmodule

// File: tb/tb_ram_rr_arbiter.sv
// Self-checking bench for ram_rr_arbiter with RD_LAT=2. A table of per-cycle
// vectors carries the inputs and the expected grants; a write-first RAM
// model sits on the RAM port. Expected read returns are pushed to a
// scoreboard queue when a read is granted and popped when they fall due.
module tb_ram_rr_arbiter;

    localparam int ADDR_W = 5;
    localparam int DATA_W = 32;
    localparam int RD_LAT = 2;

    typedef struct {
        logic              rst;
        logic              a_req;
        logic              a_we;
        logic [ADDR_W-1:0] a_addr;
        logic [DATA_W-1:0] a_wdata;
        logic              b_req;
        logic              b_we;
        logic [ADDR_W-1:0] b_addr;
        logic [DATA_W-1:0] b_wdata;
        logic              exp_a_gnt;
        logic              exp_b_gnt;
    } vec_t;

    typedef struct {
        logic              owner;
        logic [DATA_W-1:0] data;
        int                due;
    } ret_t;

    logic              clk;
    logic              rst;
    logic              preload;
    logic              ram_en;
    logic              ram_we;
    logic [ADDR_W-1:0] ram_addr;
    logic [DATA_W-1:0] ram_din;
    logic [DATA_W-1:0] ram_dout;
    logic              busy;

    logic [DATA_W-1:0] ram_mem   [1 << ADDR_W];
    logic [DATA_W-1:0] ram_rd    [RD_LAT];
    logic [DATA_W-1:0] model_mem [1 << ADDR_W];

    vec_t vecs[$];
    ret_t sb[$];
    int   cyc;
    int   tests_run;
    int   tests_failed;

    ram_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) a_bus ();
    ram_rr_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) b_bus ();

    ram_rr_arbiter #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W),
        .RD_LAT (RD_LAT)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .a        (a_bus.slave),
        .b        (b_bus.slave),
        .ram_en   (ram_en),
        .ram_we   (ram_we),
        .ram_addr (ram_addr),
        .ram_din  (ram_din),
        .ram_dout (ram_dout),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Write-first single-port RAM with RD_LAT cycles of read latency.
    always @(posedge clk) begin
        if (preload) begin
            for (int i = 0; i < (1 << ADDR_W); i++) ram_mem[i] <= '0;
            ram_mem[1] <= 32'h0000_0011;
            ram_mem[2] <= 32'h0000_0022;
        end else if (ram_en && ram_we) begin
            ram_mem[ram_addr] <= ram_din;
        end
        if (ram_en) ram_rd[0] <= ram_we ? ram_din : ram_mem[ram_addr];
        for (int i = 1; i < RD_LAT; i++) ram_rd[i] <= ram_rd[i-1];
    end
    assign ram_dout = ram_rd[RD_LAT-1];

    function automatic vec_t mk(input logic r,
                                input logic ar, input logic awe,
                                input logic [ADDR_W-1:0] aad, input logic [DATA_W-1:0] awd,
                                input logic br, input logic bwe,
                                input logic [ADDR_W-1:0] bad, input logic [DATA_W-1:0] bwd,
                                input logic ea, input logic eb);
        vec_t v;
        v.rst = r;
        v.a_req = ar; v.a_we = awe; v.a_addr = aad; v.a_wdata = awd;
        v.b_req = br; v.b_we = bwe; v.b_addr = bad; v.b_wdata = bwd;
        v.exp_a_gnt = ea; v.exp_b_gnt = eb;
        return v;
    endfunction

    function automatic vec_t idle();
        return mk(1'b0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0, '0, '0, 1'b0, 1'b0);
    endfunction

    task automatic checkVal(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("[TB] FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    // Compare the outputs of the current cycle, then advance the model.
    task automatic checkOutput(input vec_t v);
        logic              exp_en, exp_we;
        logic [ADDR_W-1:0] exp_addr;
        logic [DATA_W-1:0] exp_din;
        logic              exp_arv, exp_brv, exp_busy;
        logic [DATA_W-1:0] exp_ard, exp_brd;
        ret_t              r;

        checkVal("gnt", {62'd0, a_bus.gnt, b_bus.gnt}, {62'd0, v.exp_a_gnt, v.exp_b_gnt});

        exp_en = 1'b0; exp_we = 1'b0; exp_addr = '0; exp_din = '0;
        if (v.exp_a_gnt) begin
            exp_en = 1'b1; exp_we = v.a_we; exp_addr = v.a_addr; exp_din = v.a_wdata;
        end else if (v.exp_b_gnt) begin
            exp_en = 1'b1; exp_we = v.b_we; exp_addr = v.b_addr; exp_din = v.b_wdata;
        end
        checkVal("ram_bus", {25'd0, ram_en, ram_we, ram_addr, ram_din},
                            {25'd0, exp_en, exp_we, exp_addr, exp_din});

        if (v.rst) sb.delete();
        exp_busy = (sb.size() != 0);
        exp_arv = 1'b0; exp_ard = '0; exp_brv = 1'b0; exp_brd = '0;
        if (sb.size() != 0 && sb[0].due == cyc) begin
            r = sb.pop_front();
            if (r.owner == 1'b0) begin exp_arv = 1'b1; exp_ard = r.data; end
            else                 begin exp_brv = 1'b1; exp_brd = r.data; end
        end
        checkVal("a_return", {31'd0, a_bus.rvalid, a_bus.rdata}, {31'd0, exp_arv, exp_ard});
        checkVal("b_return", {31'd0, b_bus.rvalid, b_bus.rdata}, {31'd0, exp_brv, exp_brd});
        if (!v.rst) checkVal("busy", {63'd0, busy}, {63'd0, exp_busy});

        if (!v.rst && v.exp_a_gnt) begin
            if (v.a_we) model_mem[v.a_addr] = v.a_wdata;
            else        sb.push_back('{owner: 1'b0, data: model_mem[v.a_addr], due: cyc + RD_LAT});
        end else if (!v.rst && v.exp_b_gnt) begin
            if (v.b_we) model_mem[v.b_addr] = v.b_wdata;
            else        sb.push_back('{owner: 1'b1, data: model_mem[v.b_addr], due: cyc + RD_LAT});
        end
    endtask

    // Drive one cycle of inputs, check mid-cycle, then step past the edge.
    task automatic applyStimulus(input vec_t v);
        rst           = v.rst;
        a_bus.req     = v.a_req;
        a_bus.we      = v.a_we;
        a_bus.addr    = v.a_addr;
        a_bus.wdata   = v.a_wdata;
        b_bus.req     = v.b_req;
        b_bus.we      = v.b_we;
        b_bus.addr    = v.b_addr;
        b_bus.wdata   = v.b_wdata;
        @(negedge clk);
        checkOutput(v);
        @(posedge clk);
        #1;
        cyc++;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        cyc          = 0;
        rst          = 1'b1;
        preload      = 1'b1;
        a_bus.req = 1'b0; a_bus.we = 1'b0; a_bus.addr = '0; a_bus.wdata = '0;
        b_bus.req = 1'b0; b_bus.we = 1'b0; b_bus.addr = '0; b_bus.wdata = '0;
        for (int i = 0; i < (1 << ADDR_W); i++) model_mem[i] = '0;
        model_mem[1] = 32'h0000_0011;
        model_mem[2] = 32'h0000_0022;
        @(posedge clk);
        #1;
        preload = 1'b0;

        // Reset and idle.
        vecs.push_back(mk(1, 0,0,0,0,             0,0,0,0,             0,0));
        vecs.push_back(mk(1, 0,0,0,0,             0,0,0,0,             0,0));
        vecs.push_back(idle());
        // Single requester: write then read back.
        vecs.push_back(mk(0, 1,1,3,32'hDEADBEEF,  0,0,0,0,             1,0));
        vecs.push_back(mk(0, 1,0,3,0,             0,0,0,0,             1,0));
        vecs.push_back(idle());
        vecs.push_back(idle());
        vecs.push_back(idle());
        // Lone B write hands the pointer back to A.
        vecs.push_back(mk(0, 0,0,0,0,             1,1,10,32'hCAFEF00D, 0,1));
        // Continuous contention: grants alternate starting with A.
        for (int k = 0; k < 6; k++)
            vecs.push_back(mk(0, 1,0,1,0,         1,0,2,0,             (k % 2) == 0, (k % 2) == 1));
        vecs.push_back(idle());
        vecs.push_back(idle());
        // Write by A then read of the same address by B.
        vecs.push_back(mk(0, 1,1,7,32'h5A5A5A5A,  1,0,7,0,             1,0));
        vecs.push_back(mk(0, 0,0,0,0,             1,0,7,0,             0,1));
        vecs.push_back(idle());
        vecs.push_back(idle());
        // Withdrawal: B loses, drops its request, pointer holds on the idle cycle.
        vecs.push_back(mk(0, 1,0,2,0,             1,0,3,0,             1,0));
        vecs.push_back(idle());
        vecs.push_back(mk(0, 1,0,2,0,             1,0,3,0,             0,1));
        vecs.push_back(idle());
        vecs.push_back(idle());

        foreach (vecs[i]) applyStimulus(vecs[i]);

        // Reset while two B reads are in flight: neither may ever return.
        applyStimulus(mk(0, 0,0,0,0,              1,0,1,0,             0,1));
        applyStimulus(mk(0, 0,0,0,0,              1,0,2,0,             0,1));
        applyStimulus(mk(1, 1,1,5,32'hFFFF0000,   1,0,1,0,             0,0));
        for (int k = 0; k < 3; k++) applyStimulus(idle());

        // Reset returns the pointer to A even after an A grant favoured B.
        applyStimulus(mk(0, 1,1,12,32'h00001234,  0,0,0,0,             1,0));
        applyStimulus(mk(1, 0,0,0,0,              0,0,0,0,             0,0));
        applyStimulus(mk(0, 1,0,12,0,             1,0,1,0,             1,0));
        applyStimulus(mk(0, 1,0,1,0,              1,0,12,0,            0,1));
        applyStimulus(mk(0, 1,0,5,0,              0,0,0,0,             1,0));
        for (int k = 0; k < 4; k++) applyStimulus(idle());

        checkVal("drain", 64'(sb.size()), 64'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
